// File: rtl/stream_demux_n.sv
// stream_demux_n: single-register 1-to-N stream demux, addressed or round-robin routing
module stream_demux_n #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3,
    localparam int N     = 2 ** SEL_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    output logic [N-1:0]        out_valid,
    output logic [N*DATA_W-1:0] out_data,
    input  logic [N-1:0]        out_ready,
    output logic [SEL_W-1:0]    rr_ptr,
    output logic [15:0]         xfer_cnt
);
    logic              hold_valid_q, hold_valid_d;
    logic [SEL_W-1:0]  hold_dest_q, hold_dest_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [15:0]       xfer_cnt_q, xfer_cnt_d;
    logic              accept, xfer;

    assign xfer     = !rst && hold_valid_q && out_ready[hold_dest_q];
    assign in_ready = !rst && (!hold_valid_q || out_ready[hold_dest_q]);
    assign accept   = in_valid && in_ready;
    assign rr_ptr   = rr_ptr_q;
    assign xfer_cnt = xfer_cnt_q;

    always_comb begin
        hold_valid_d = accept ? 1'b1 : (xfer ? 1'b0 : hold_valid_q);
        hold_dest_d  = accept ? (mode ? rr_ptr_q : sel) : hold_dest_q;
        hold_data_d  = accept ? in_data : hold_data_q;
        rr_ptr_d     = (accept && mode) ? rr_ptr_q + SEL_W'(1) : rr_ptr_q;
        xfer_cnt_d   = (xfer && xfer_cnt_q != 16'hFFFF) ? xfer_cnt_q + 16'd1 : xfer_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_dest_q  <= '0;
            hold_data_q  <= '0;
            rr_ptr_q     <= '0;
            xfer_cnt_q   <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_dest_q  <= hold_dest_d;
            hold_data_q  <= hold_data_d;
            rr_ptr_q     <= rr_ptr_d;
            xfer_cnt_q   <= xfer_cnt_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        assign out_valid[i] = hold_valid_q && hold_dest_q == SEL_W'(i);
        assign out_data[i*DATA_W +: DATA_W] = out_valid[i] ? hold_data_q : '0;
    end
endmodule
